// File: rtl/dog_pkg.sv
// Shared types and helpers for the multi-layer difference-of-Gaussians streamer.
package dog_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  // A signed difference of two unsigned pixels needs one extra bit.
  function automatic int layer_w(input int pix_width);
    return pix_width + 1;
  endfunction

endpackage

// File: rtl/dog_stream_if.sv
// Octave-read / DoG-write BRAM bus between dog_stream (master) and the memories (slave).
interface dog_stream_if
  import dog_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_SCALES = 3,
  parameter int PIX_WIDTH  = 8
);

  localparam int L  = NUM_SCALES - 1;
  localparam int LW = layer_w(PIX_WIDTH);

  logic                            rd_en;
  logic [ADDR_WIDTH-1:0]           rd_addr;
  logic [NUM_SCALES*PIX_WIDTH-1:0] pix_in;
  logic                            wea;
  logic [ADDR_WIDTH-1:0]           wr_addr;
  logic [L*LW-1:0]                 wr_data;

  modport master (
    output rd_en, rd_addr, wea, wr_addr, wr_data,
    input  pix_in
  );

  modport slave (
    input  rd_en, rd_addr, wea, wr_addr, wr_data,
    output pix_in
  );

endinterface

// File: rtl/dog_lane.sv
// One DoG layer: registers the signed difference of two adjacent scales and
// tracks the largest absolute difference seen since the last clear.
module dog_lane
  import dog_pkg::*;
#(
  parameter int PIX_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n_in,
  input  logic [PIX_WIDTH-1:0]   pix_a,
  input  logic [PIX_WIDTH-1:0]   pix_b,
  input  logic                   valid,
  input  logic                   clear,
  output logic signed [PIX_WIDTH:0] diff,
  output logic [PIX_WIDTH-1:0]   max_abs
);

  localparam int LW = layer_w(PIX_WIDTH);

  logic signed [LW-1:0]  diff_c;
  logic [PIX_WIDTH-1:0]  abs_c;

  // |diff| never exceeds 2^PIX_WIDTH-1, so dropping the sign bit after negation is exact.
  always_comb begin
    diff_c = $signed({1'b0, pix_a}) - $signed({1'b0, pix_b});
    abs_c  = diff_c[LW-1] ? PIX_WIDTH'(-diff_c) : PIX_WIDTH'(diff_c);
  end

  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      diff    <= '0;
      max_abs <= '0;
    end else begin
      if (valid) diff <= diff_c;
      if (clear) begin
        max_abs <= '0;
      end else if (valid && (abs_c > max_abs)) begin
        max_abs <= abs_c;
      end
    end
  end

endmodule

// File: rtl/dog_stream.sv
// Streams an octave's scale images from BRAM and writes all NUM_SCALES-1 DoG
// layers per pixel on one write port, tracking per-layer peak |diff|.
module dog_stream
  import dog_pkg::*;
#(
  parameter int DIMENSION    = 64,
  parameter int NUM_SCALES   = 3,
  parameter int PIX_WIDTH    = 8,
  parameter int READ_LATENCY = 2,
  localparam int N           = DIMENSION * DIMENSION,
  localparam int ADDR_WIDTH  = (N > 1) ? $clog2(N) : 1,
  localparam int L           = NUM_SCALES - 1
) (
  input  logic                   clk,
  input  logic                   rst_n_in,
  input  logic                   start_in,
  dog_stream_if.master           bus,
  output logic                   busy,
  output logic                   done,
  output logic [STATE_W-1:0]     state_num,
  output logic [L*PIX_WIDTH-1:0] max_abs
);

  localparam int LW = layer_w(PIX_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N - 1);

  state_t                 state, next_state;
  logic                   start_q;
  logic                   start_edge, run_start, last_wr;
  logic [ADDR_WIDTH-1:0]  rd_cnt;
  logic [READ_LATENCY-1:0] vld_sr;
  logic [ADDR_WIDTH-1:0]  addr_sr [READ_LATENCY];
  logic                   wea_q;
  logic [ADDR_WIDTH-1:0]  wr_addr_q;
  logic [L*LW-1:0]        wr_data_c;

  assign start_edge = start_in & ~start_q;
  assign run_start  = (state == IDLE) && start_edge;
  assign last_wr    = wea_q && (wr_addr_q == LAST_ADDR);

  // NOTE: state is sequential, so it takes <=; mixing = here would race with every reader of state.
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= next_state;
  end

  // NOTE: next_state defaults to state before the case, so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_edge)           next_state = STREAM;
      STREAM:  if (rd_cnt == LAST_ADDR)  next_state = DRAIN;
      DRAIN:   if (last_wr)              next_state = IDLE;
      default:                           next_state = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    state_num   = state;
    bus.rd_en   = (state == STREAM);
    bus.rd_addr = rd_cnt;
    bus.wea     = wea_q;
    bus.wr_addr = wr_addr_q;
    bus.wr_data = wr_data_c;
  end

  // Start register resets high so a start held through reset is not seen as an edge.
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      start_q   <= 1'b1;
      rd_cnt    <= '0;
      done      <= 1'b0;
      vld_sr    <= '0;
      wea_q     <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      start_q <= start_in;
      rd_cnt  <= ((state == STREAM) && (rd_cnt != LAST_ADDR)) ? rd_cnt + 1'b1 : '0;
      done    <= (state == DRAIN) && last_wr;
      vld_sr[0] <= bus.rd_en;
      for (int i = 1; i < READ_LATENCY; i++) vld_sr[i] <= vld_sr[i-1];
      wea_q <= vld_sr[READ_LATENCY-1];
      if (vld_sr[READ_LATENCY-1]) wr_addr_q <= addr_sr[READ_LATENCY-1];
    end
  end

  // NOTE: the address delay line is data-only and always qualified by vld_sr, so it is left unreset.
  always_ff @(posedge clk) begin
    addr_sr[0] <= rd_cnt;
    for (int i = 1; i < READ_LATENCY; i++) addr_sr[i] <= addr_sr[i-1];
  end

  for (genvar i = 0; i < L; i++) begin : g_lane
    dog_lane #(.PIX_WIDTH(PIX_WIDTH)) u_lane (
      .clk      (clk),
      .rst_n_in (rst_n_in),
      .pix_a    (bus.pix_in[i*PIX_WIDTH +: PIX_WIDTH]),
      .pix_b    (bus.pix_in[(i+1)*PIX_WIDTH +: PIX_WIDTH]),
      .valid    (vld_sr[READ_LATENCY-1]),
      .clear    (run_start),
      .diff     (wr_data_c[i*LW +: LW]),
      .max_abs  (max_abs[i*PIX_WIDTH +: PIX_WIDTH])
    );
  end

endmodule

// File: tb/tb_dog_stream.sv
// Scoreboard bench for dog_stream: 4x4 image, 3 scales, read latency 2, plus a latency-1 instance.
module tb_dog_stream;

  localparam int DIM = 4;
  localparam int NS  = 3;
  localparam int PW  = 8;
  localparam int N   = DIM * DIM;
  localparam int AW  = 4;
  localparam int MW  = (NS - 1) * PW;

  logic clk = 1'b0;
  logic rst_n_in = 1'b0;
  logic start_in = 1'b1;
  logic start2 = 1'b0;
  always #5 clk = ~clk;

  logic          busy, done, busy2, done2;
  logic [1:0]    state_num, state_num2;
  logic [MW-1:0] max_abs, max_abs2;

  dog_stream_if #(.ADDR_WIDTH(AW), .NUM_SCALES(NS), .PIX_WIDTH(PW)) bus ();
  dog_stream_if #(.ADDR_WIDTH(AW), .NUM_SCALES(NS), .PIX_WIDTH(PW)) bus2 ();

  dog_stream #(.DIMENSION(DIM), .NUM_SCALES(NS), .PIX_WIDTH(PW), .READ_LATENCY(2)) dut (
    .clk(clk), .rst_n_in(rst_n_in), .start_in(start_in), .bus(bus),
    .busy(busy), .done(done), .state_num(state_num), .max_abs(max_abs)
  );

  dog_stream #(.DIMENSION(DIM), .NUM_SCALES(NS), .PIX_WIDTH(PW), .READ_LATENCY(1)) dut2 (
    .clk(clk), .rst_n_in(rst_n_in), .start_in(start2), .bus(bus2),
    .busy(busy2), .done(done2), .state_num(state_num2), .max_abs(max_abs2)
  );

  // BRAM model: scale images as functions of address, with registered read latency.
  typedef enum {RAMP, NEG} mode_t;
  mode_t mode = RAMP;

  function automatic logic [NS*PW-1:0] bram(input mode_t m, input logic [AW-1:0] a);
    if (m == RAMP) return {8'd0, 8'(5 * a), 8'(10 * a)};
    return {8'd0, 8'd255, 8'd0};
  endfunction

  logic [AW-1:0] ap1, ap2, bp1;
  always @(posedge clk) begin
    ap1 <= bus.rd_addr;
    ap2 <= ap1;
    bp1 <= bus2.rd_addr;
  end
  assign bus.pix_in  = bram(mode, ap2);
  assign bus2.pix_in = bram(RAMP, bp1);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic spurious(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got unexpected event value %0d at cycle %0d, expected none", name, act, cyc);
  endtask

  // Scoreboard queues, filled by the stimulus and drained by the monitor.
  typedef struct {
    int          cyc;
    logic [31:0] val;
    logic [31:0] val2;
  } exp_t;

  exp_t rd_q[$];
  exp_t wr_q[$];
  exp_t done_q[$];
  exp_t me;

  always @(negedge clk) begin
    if (rst_n_in) begin
      if (bus.rd_en) begin
        if (rd_q.size() == 0) spurious("rd_spurious", bus.rd_addr);
        else begin
          me = rd_q.pop_front();
          check("rd_cyc", cyc, me.cyc);
          check("rd_addr", bus.rd_addr, me.val);
        end
      end
      if (bus.wea) begin
        if (wr_q.size() == 0) spurious("wr_spurious", bus.wr_addr);
        else begin
          me = wr_q.pop_front();
          check("wr_cyc", cyc, me.cyc);
          check("wr_addr", bus.wr_addr, me.val);
          check("wr_data", bus.wr_data, me.val2);
        end
      end
      if (done) begin
        if (done_q.size() == 0) spurious("done_spurious", max_abs);
        else begin
          me = done_q.pop_front();
          check("done_cyc", cyc, me.cyc);
          check("max_abs", max_abs, me.val);
        end
      end
    end
  end

  // Latency-1 instance checked inline against hand-derived ramp values.
  int s6 = -1000;
  int idx2 = 0;
  bit done2_seen = 1'b0;
  always @(negedge clk) begin
    if (rst_n_in) begin
      if (bus2.wea) begin
        check("rl1_wr_cyc", cyc, s6 + 3 + idx2);
        check("rl1_wr_addr", bus2.wr_addr, idx2);
        check("rl1_wr_data", bus2.wr_data, {9'(5 * idx2), 9'(5 * idx2)});
        idx2++;
      end
      if (done2) begin
        check("rl1_done_cyc", cyc, s6 + 19);
        check("rl1_max_abs", max_abs2, {8'd75, 8'd75});
        done2_seen = 1'b1;
      end
    end
  end

  task automatic go_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push_run(input int s, input mode_t m, input int nrd, input int nwr, input bit with_done);
    logic [17:0] d;
    for (int k = 0; k < nrd; k++) rd_q.push_back(exp_t'{cyc: s + 1 + k, val: k, val2: 0});
    for (int k = 0; k < nwr; k++) begin
      d = (m == RAMP) ? {9'(5 * k), 9'(5 * k)} : {9'h0FF, 9'h101};
      wr_q.push_back(exp_t'{cyc: s + 4 + k, val: k, val2: 32'(d)});
    end
    if (with_done)
      done_q.push_back(exp_t'{cyc: s + 20,
                              val: (m == RAMP) ? 32'({8'd75, 8'd75}) : 32'({8'd255, 8'd255}),
                              val2: 0});
  endtask

  task automatic wait_drain(input int budget);
    int t0;
    t0 = cyc;
    while (((rd_q.size() + wr_q.size() + done_q.size()) != 0) && (cyc < t0 + budget)) go_cyc(cyc + 1);
    check("pending_expectations", rd_q.size() + wr_q.size() + done_q.size(), 0);
    rd_q.delete();
    wr_q.delete();
    done_q.delete();
    go_cyc(cyc + 4);
  endtask

  task automatic start_pulse(input mode_t m);
    int s;
    s = cyc;
    mode = m;
    start_in = 1'b1;
    push_run(s, m, N, N, 1'b1);
    go_cyc(s + 1);
    start_in = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int s, s2;

    // Reset with start held high.
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", state_num, 0);
    check("rst_max", max_abs, 0);
    check("rst_rd_en", bus.rd_en, 0);
    check("rst_rd_addr", bus.rd_addr, 0);
    check("rst_wea", bus.wea, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_data", bus.wr_data, 0);
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst_n_in = 1'b1;
    go_cyc(cyc + 3);
    check("held_start_busy", busy, 0);
    check("held_start_state", state_num, 0);
    start_in = 1'b0;
    go_cyc(cyc + 2);

    // Ramp data.
    start_pulse(RAMP);
    wait_drain(40);

    // Negative/positive extremes.
    start_pulse(NEG);
    wait_drain(40);

    // Start held high with an extra edge mid-stream.
    mode = RAMP;
    s = cyc;
    start_in = 1'b1;
    push_run(s, RAMP, N, N, 1'b1);
    go_cyc(s + 1);
    check("s3_state_stream", state_num, 1);
    check("s3_busy", busy, 1);
    go_cyc(s + 7);
    start_in = 1'b0;
    go_cyc(s + 8);
    start_in = 1'b1;
    go_cyc(s + 16);
    check("s3_state_last_rd", state_num, 1);
    go_cyc(s + 17);
    check("s3_state_drain", state_num, 2);
    check("s3_rd_en_drain", bus.rd_en, 0);
    go_cyc(s + 20);
    check("s3_state_idle", state_num, 0);
    check("s3_busy_end", busy, 0);
    go_cyc(s + 30);
    start_in = 1'b0;
    wait_drain(40);

    // Reset during the write of address 7.
    s = cyc;
    start_in = 1'b1;
    push_run(s, RAMP, 10, 7, 1'b0);
    go_cyc(s + 1);
    start_in = 1'b0;
    go_cyc(s + 11);
    rst_n_in = 1'b0;
    #1;
    check("mid_rst_wea", bus.wea, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_state", state_num, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_rd_en", bus.rd_en, 0);
    check("mid_rst_pending", rd_q.size() + wr_q.size(), 0);
    go_cyc(s + 13);
    rst_n_in = 1'b1;
    check("post_rst_max", max_abs, 0);
    go_cyc(s + 14);
    start_pulse(RAMP);
    wait_drain(40);

    // Back-to-back: new start edge during the done cycle.
    s = cyc;
    start_pulse(RAMP);
    go_cyc(s + 20);
    mode = NEG;
    start_in = 1'b1;
    s2 = cyc;
    push_run(s2, NEG, N, N, 1'b1);
    go_cyc(s2 + 1);
    check("b2b_busy", busy, 1);
    check("b2b_max_cleared", max_abs, 0);
    start_in = 1'b0;
    wait_drain(50);

    // Read latency 1 instance.
    s6 = cyc;
    start2 = 1'b1;
    go_cyc(s6 + 1);
    start2 = 1'b0;
    while (!done2_seen && (cyc < s6 + 40)) go_cyc(cyc + 1);
    check("rl1_done_seen", done2_seen, 1);
    check("rl1_write_count", idx2, N);
    wait_drain(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dog_stream.md
Name: dog_stream

Overview:
- Parametrised successor to the single-layer difference-of-Gaussians writer.
- Streams one pixel per cycle from an octave's NUM_SCALES blurred images, read in parallel at a shared address.
- Computes NUM_SCALES-1 signed DoG layers at once and writes them all on one shared write port.
- Tracks the per-layer maximum absolute response for downstream keypoint thresholding.
- Sits between the blur stage's octave BRAMs and the DoG BRAMs / extrema detector.

Parameters:
- DIMENSION, 64, square image side; pixel count N = DIMENSION*DIMENSION.
- NUM_SCALES, 3, blurred images per octave (at least 2); layer count L = NUM_SCALES-1.
- PIX_WIDTH, 8, unsigned greyscale pixel width.
- READ_LATENCY, 2, BRAM read latency in cycles (at least 1).
- ADDR_WIDTH, localparam, $clog2(N), minimum 1.

Ports:
- clk  in  1  system clock.
- rst_n_in  in  1  asynchronous, active-low reset.
- start_in  in  1  octave BRAMs ready; rising edge starts a run.
- rd_en  out  1  read enable to all scale BRAMs.
- rd_addr  out  ADDR_WIDTH  shared read address.
- pix_in  in  NUM_SCALES*PIX_WIDTH  packed read data; scale 0 (sharpest) in the LSBs.
- wea  out  1  write enable to the DoG BRAM(s).
- wr_addr  out  ADDR_WIDTH  write address.
- wr_data  out  L*(PIX_WIDTH+1)  packed signed layers; layer 0 in the LSBs.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse when a run completes.
- state_num  out  2  0=IDLE, 1=STREAM, 2=DRAIN.
- max_abs  out  L*PIX_WIDTH  per-layer maximum of |diff| over the last run.

Behaviour:
- Reset (async, rst_n_in=0): all outputs 0; state IDLE; start edge register set to 1, so start_in held high through reset does not trigger a run.
- Start detection: start_q <= start_in every cycle. A run begins only in IDLE when start_in & ~start_q. Edges in STREAM or DRAIN are ignored. Holding start_in high gives exactly one run.
- STREAM:
  - Entered the cycle after the start edge; busy=1, rd_en=1.
  - rd_addr = 0 on the first STREAM cycle, +1 per cycle.
  - After issuing rd_addr = N-1, go to DRAIN; rd_en=0, rd_addr returns to 0.
- Pipeline:
  - A valid shift register of depth READ_LATENCY tracks reads; an address shift register of the same depth tracks their addresses.
  - Read issued at cycle t: pix_in is sampled at t+READ_LATENCY; wea=1, wr_addr=k and wr_data are registered at t+READ_LATENCY+1.
  - Writes are contiguous, one per cycle, N total.
- DRAIN: rd_en=0; wait until the last write (addr N-1) is presented. In the following cycle: state IDLE, busy=0, wea=0, done=1 for exactly that cycle.
- Run length: busy high for N+READ_LATENCY+1 cycles.
- Back-to-back runs: a start edge in the same cycle done=1 (already IDLE) is accepted.
- Arithmetic, per layer i:
  - diff_i = {1'b0,pix[i]} - {1'b0,pix[i+1]}, signed PIX_WIDTH+1 bits.
  - Range ±(2^PIX_WIDTH-1), so no overflow and no saturation.
  - |diff_i| fits PIX_WIDTH bits.
- max_abs:
  - Cleared to 0 on run start.
  - Updated to max(current, |diff_i|) on each wea cycle.
  - Final after the last write; held through IDLE until the next start.
- wr_data and wr_addr hold their last values when wea=0.
- Reset mid-run: outputs clear immediately, no further wea, partial results abandoned. After release, a new start edge must start a clean run from address 0.
- N=1 (DIMENSION=1): one read, one write, done after READ_LATENCY+2 cycles.

Decomposition:
- Shared package dog_pkg holds:
  - state enum {IDLE=0, STREAM=1, DRAIN=2};
  - STATE_W = 2;
  - helper function for the layer width, PIX_WIDTH+1.
- Sub-module dog_lane, instantiated L times via generate. Each lane:
  - takes two pixels and a valid;
  - registers the signed diff;
  - maintains its own max_abs, with a clear input.
- Top level owns the FSM, address counter, valid/address delay lines and start edge detection.

Test Plan:
All cases use DIMENSION=4, NUM_SCALES=3, PIX_WIDTH=8, READ_LATENCY=2 unless noted.
1. Ramp: BRAM model returns scale0=10*addr, scale1=5*addr, scale2=0; start edge at cycle 0 -> rd_addr 0..15 on cycles 1..16; wea cycles 4..19 with wr_addr 0..15; layer0=layer1=5*addr; done=1 at cycle 20 only; max_abs={75,75}.
2. Negative: scale0=0, scale1=255, scale2=0 for all addresses -> layer0=-255 (9'h101), layer1=+255 (9'h0FF); max_abs={255,255}.
3. Start held high for 30 cycles, plus a second pulse at cycle 8 -> exactly 16 writes and one done pulse; state_num follows 1 then 2 then 0.
4. Reset mid-run: rst_n_in low during write of addr 7 -> wea, busy, state_num, done at 0 the same cycle. After release, a new start edge gives a full 16-write run from addr 0.
5. Back-to-back: start edge coincident with done -> busy re-asserts next cycle, rd_addr restarts at 0; max_abs cleared then recomputed.
6. Latency variant, READ_LATENCY=1 with scenario 1 data -> first wea on cycle 3, done on cycle 19.
